ft245reader: RTL and testbench

Receive-side FT245 synchronous-FIFO engine for the FT2232H link; mirror of `ft245writer` on the same 60 MHz `ft_clk_i` domain. It pulls host-to-device bytes off the FT2232H bus using RXF#/OE#/RD#. It pushes them into a downstream byte FIFO (host command path) through a 2-entry skid buffer, so backpressure never drops or duplicates a byte. It sits between the FT2232H pins and the command FIFO feeding the DAQ control logic.

---
 rtl/ft245reader.sv | 104 ++++++++++
 tb/tb_ft245reader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245reader.sv
// FT245 synchronous-FIFO receive engine: pulls bytes off the FT2232H bus with
// RXF#/OE#/RD# and forwards them downstream through a 2-entry skid buffer.
module ft245reader (
  input  logic       ft_clk_i,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic       ft_rxf_i,
  input  logic [7:0] ft_data_i,
  output logic       ft_oe_o,
  output logic       ft_rd_o,
  output logic       fifo_wr_clk_o,
  output logic [7:0] fifo_wr_data_o,
  output logic       fifo_wr_en_o,
  input  logic       fifo_wr_full_i,
  output logic [15:0] rx_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_OE, S_READ} state_t;

  state_t     state, state_nxt;
  logic       oe_nxt, rd_nxt;
  logic [1:0] cnt, cnt_nxt, wr_idx;
  logic [7:0] skid_p0, skid_p1;
  logic       cap, drain;

  assign fifo_wr_clk_o  = ft_clk_i;
  assign cap            = !ft_rd_o && !ft_rxf_i;
  assign drain          = (cnt != 2'd0) && !fifo_wr_full_i;
  assign fifo_wr_en_o   = drain;
  assign fifo_wr_data_o = skid_p0;
  assign cnt_nxt        = cnt + {1'b0, cap} - {1'b0, drain};
  // Slot the captured byte lands in, after any same-edge shift-out.
  assign wr_idx         = cnt - {1'b0, drain};

  always_comb begin
    state_nxt = state;
    oe_nxt    = ft_oe_o;
    rd_nxt    = ft_rd_o;
    case (state)
      S_IDLE: begin
        oe_nxt = 1'b1;
        rd_nxt = 1'b1;
        if (en_i && !ft_rxf_i && (cnt == 2'd0)) begin
          state_nxt = S_OE;
          oe_nxt    = 1'b0;
        end
      end
      S_OE: begin
        if (ft_rxf_i) begin
          state_nxt = S_IDLE;
          oe_nxt    = 1'b1;
          rd_nxt    = 1'b1;
        end else begin
          state_nxt = S_READ;
          oe_nxt    = 1'b0;
          rd_nxt    = 1'b0;
        end
      end
      S_READ: begin
        if (ft_rxf_i || !en_i) begin
          state_nxt = S_IDLE;
          oe_nxt    = 1'b1;
          rd_nxt    = 1'b1;
        end else begin
          // Keep RD# low only while the skid can absorb the byte in flight.
          oe_nxt = 1'b0;
          rd_nxt = (cnt_nxt == 2'd2);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        oe_nxt    = 1'b1;
        rd_nxt    = 1'b1;
      end
    endcase
  end

  // Control stage: FSM, pin strobes, occupancy and byte counter
  always_ff @(posedge ft_clk_i) begin
    if (reset_i) begin
      state      <= S_IDLE;
      ft_oe_o    <= 1'b1;
      ft_rd_o    <= 1'b1;
      cnt        <= 2'd0;
      rx_count_o <= 16'd0;
    end else begin
      state   <= state_nxt;
      ft_oe_o <= oe_nxt;
      ft_rd_o <= rd_nxt;
      cnt     <= cnt_nxt;
      if (drain) rx_count_o <= rx_count_o + 16'd1;
    end
  end

  // Data stage: skid entries, head in skid_p0
  always_ff @(posedge ft_clk_i) begin
    if (drain) skid_p0 <= skid_p1;
    if (cap) begin
      if (wr_idx == 2'd0) skid_p0 <= ft_data_i;
      else                skid_p1 <= ft_data_i;
    end
  end

endmodule

// File: tb/tb_ft245reader.sv
// Bench for ft245reader: queue-based model of the FT245 read protocol and skid
// buffer, checked every cycle, plus directed literal checks and random traffic.
module tb_ft245reader;

  logic        clk = 1'b0;
  logic        rst, en, rxf, full;
  logic [7:0]  data;
  logic        oe_n, rd_n, wr_clk, wr_en;
  logic [7:0]  wr_data;
  logic [15:0] rx_count;

  always #5 clk = ~clk;

  ft245reader dut (
    .ft_clk_i       (clk),
    .reset_i        (rst),
    .en_i           (en),
    .ft_rxf_i       (rxf),
    .ft_data_i      (data),
    .ft_oe_o        (oe_n),
    .ft_rd_o        (rd_n),
    .fifo_wr_clk_o  (wr_clk),
    .fifo_wr_data_o (wr_data),
    .fifo_wr_en_o   (wr_en),
    .fifo_wr_full_i (full),
    .rx_count_o     (rx_count)
  );

  localparam int PH_IDLE = 0, PH_OE = 1, PH_READ = 2;

  int          n_tests = 0, n_fail = 0;
  logic [7:0]  mq[$];     // model skid contents
  logic [7:0]  hq[$];     // bytes the host will present, in order
  logic [7:0]  wlog[$];   // bytes the DUT actually wrote downstream
  logic        m_oe = 1'b1, m_rd = 1'b1;
  int          m_ph = PH_IDLE;
  logic [15:0] m_count = 16'd0;
  int          m_caps = 0, m_writes = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: queue-based skid plus the protocol rules for OE#/RD#.
  always @(posedge clk) begin : model
    logic c_m, d_m;
    int   pre;
    if (rst) begin
      mq.delete();
      m_oe = 1'b1; m_rd = 1'b1; m_ph = PH_IDLE; m_count = 16'd0;
    end else begin
      pre = mq.size();
      c_m = !m_rd && !rxf;
      d_m = (pre != 0) && !full;
      if (d_m) begin
        void'(mq.pop_front());
        m_count = m_count + 16'd1;
        m_writes++;
      end
      if (c_m) begin
        mq.push_back(data);
        m_caps++;
        if (hq.size() > 0) void'(hq.pop_front());
      end
      case (m_ph)
        PH_IDLE: if (en && !rxf && pre == 0) begin m_ph = PH_OE; m_oe = 1'b0; end
        PH_OE: begin
          if (rxf) begin m_ph = PH_IDLE; m_oe = 1'b1; end
          else     begin m_ph = PH_READ; m_rd = 1'b0; end
        end
        default: begin
          if (rxf || !en) begin m_ph = PH_IDLE; m_oe = 1'b1; m_rd = 1'b1; end
          else m_rd = (mq.size() >= 2);
        end
      endcase
    end
  end

  // Host drives the next byte on the bus away from the sampling edge.
  always @(negedge clk)
    data = (hq.size() > 0) ? hq[0] : 8'($urandom);

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #2;
    chk("oe_n", oe_n, m_oe);
    chk("rd_n", rd_n, m_rd);
    chk("wr_en", wr_en, (mq.size() != 0) && !full);
    if (mq.size() != 0 && !full) chk("wr_data", wr_data, mq[0]);
    chk("rx_count", rx_count, m_count);
    chk("wr_clk", wr_clk, 1'b1);
    if (wr_en === 1'b1) wlog.push_back(wr_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #1;
  endtask

  initial begin
    int c0, w0, fcnt;
    logic [7:0] pat[6];
    rst = 1'b1; en = 1'b0; rxf = 1'b1; full = 1'b0; data = 8'h00;
    repeat (2) step();
    look();
    chk("rst_oe", oe_n, 1'b1);
    chk("rst_rd", rd_n, 1'b1);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_count", rx_count, 16'd0);
    step();
    rst = 1'b0;
    repeat (2) step();

    // Burst with free downstream FIFO
    wlog.delete();
    en = 1'b1;
    hq = '{8'h11, 8'h22, 8'h33, 8'h44};
    rxf = 1'b0;
    step(); look();                         // E0
    chk("lat_oe_e0", oe_n, 1'b0);
    chk("lat_rd_e0", rd_n, 1'b1);
    step(); look();                         // E1
    chk("lat_rd_e1", rd_n, 1'b0);
    step(); look();                         // E2
    chk("lat_wr_en_e2", wr_en, 1'b1);
    chk("lat_data_e2", wr_data, 8'h11);
    step(); look();                         // E3
    chk("burst_count_e3", rx_count, 16'd1);
    step();                                 // E4
    step();                                 // E5
    rxf = 1'b1;
    step(); look();                         // E6
    chk("burst_oe_end", oe_n, 1'b1);
    chk("burst_rd_end", rd_n, 1'b1);
    chk("burst_count", rx_count, 16'd4);
    step();
    chk("burst_nwr", wlog.size(), 4);
    if (wlog.size() >= 4) begin
      chk("burst_b0", wlog[0], 8'h11);
      chk("burst_b1", wlog[1], 8'h22);
      chk("burst_b2", wlog[2], 8'h33);
      chk("burst_b3", wlog[3], 8'h44);
    end

    // Enable gating
    en = 1'b0; rxf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(); look();
      chk("gate_oe_idle", oe_n, 1'b1);
    end
    en = 1'b1;
    repeat (5) step();
    en = 1'b0;
    step(); look();
    chk("gate_rd_stop", rd_n, 1'b1);
    chk("gate_oe_stop", oe_n, 1'b1);
    rxf = 1'b1;
    repeat (5) step();

    // RXF# gap after two bytes
    wlog.delete();
    en = 1'b1;
    hq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    c0 = m_caps;
    rxf = 1'b0;
    for (int i = 0; i < 20 && (m_caps - c0) < 2; i++) step();
    chk("gap_caps", m_caps - c0, 2);
    rxf = 1'b1;
    repeat (3) step();
    rxf = 1'b0;
    repeat (8) step();
    rxf = 1'b1;
    repeat (4) step();
    chk("gap_nwr_ge4", wlog.size() >= 4, 1'b1);
    if (wlog.size() >= 4) begin
      chk("gap_b0", wlog[0], 8'hA1);
      chk("gap_b1", wlog[1], 8'hA2);
      chk("gap_b2", wlog[2], 8'hA3);
      chk("gap_b3", wlog[3], 8'hA4);
    end

    // Backpressure during a 6-byte burst
    wlog.delete();
    for (int i = 0; i < 6; i++) begin
      pat[i] = 8'($urandom);
      hq.push_back(pat[i]);
    end
    c0 = m_caps; w0 = m_writes; fcnt = -1;
    rxf = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m_caps - c0 >= 6) rxf = 1'b1;
      if (fcnt < 0 && (m_writes - w0) == 1) begin
        full = 1'b1; fcnt = 5;
      end else if (fcnt > 0) begin
        fcnt--;
        if (fcnt == 0) full = 1'b0;
      end
    end
    rxf = 1'b1; full = 1'b0;
    repeat (3) step();
    chk("bp_nwr", wlog.size(), 6);
    for (int i = 0; i < 6 && i < wlog.size(); i++) chk("bp_byte", wlog[i], pat[i]);

    // Reset mid-burst
    hq = '{8'hC1, 8'hC2, 8'hC3};
    c0 = m_caps;
    rxf = 1'b0;
    for (int i = 0; i < 20 && (m_caps - c0) < 2; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0; rxf = 1'b1;
    hq.delete();
    wlog.delete();
    look();
    chk("mrst_oe", oe_n, 1'b1);
    chk("mrst_rd", rd_n, 1'b1);
    chk("mrst_wr_en", wr_en, 1'b0);
    chk("mrst_count", rx_count, 16'd0);
    repeat (5) step();
    chk("mrst_no_stale", wlog.size(), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      en   = ($urandom_range(0, 9) != 0);
      rxf  = ($urandom_range(0, 9) < 3);
      full = ($urandom_range(0, 9) < 3);
    end
    rxf = 1'b1; full = 1'b0;
    repeat (6) step();

    // Counter wrap
    rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b1; full = 1'b0; rxf = 1'b0;
    begin
      int n;
      for (n = 0; n < 70000 && m_count != 16'hFFFF; n++) step();
      chk("wrap_budget", n < 70000, 1'b1);
    end
    look();
    chk("wrap_ffff", rx_count, 16'hFFFF);
    step(); look();
    chk("wrap_0000", rx_count, 16'h0000);
    step(); look();
    chk("wrap_0001", rx_count, 16'h0001);
    rxf = 1'b1;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
